// File: rtl/adcmem_frame_ctrl_if.sv
// adcmem_frame_ctrl_if: ADC sample stream into the frame ring and frame word stream out of it
interface adcmem_frame_ctrl_if #(parameter int DATA_W = 16);
  logic              wr_valid;
  logic              wr_sof;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  modport master (output wr_valid, wr_sof, wr_data, rd_ready, input wr_ready, rd_valid, rd_data, rd_last);
  modport slave (input wr_valid, wr_sof, wr_data, rd_ready, output wr_ready, rd_valid, rd_data, rd_last);
endinterface

// File: rtl/adcmem_frame_ctrl.sv
// adcmem_frame_ctrl: runs the dual-port ADC sample memory as a ring of fixed-size frames
module adcmem_frame_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int CH = 64,
  parameter int NUM_FRAMES = 8,
  localparam int CW = $clog2(CH),
  localparam int SW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int FW = $clog2(NUM_FRAMES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  adcmem_frame_ctrl_if.slave bus,
  output logic [FW-1:0]     frames_avail,
  output logic [7:0]        ovf_cnt,
  output logic              sof_err,
  output logic [ADDR_W-1:0] mem_addr_0,
  output logic [DATA_W-1:0] mem_din_0,
  output logic              mem_we_0,
  output logic              mem_re_0,
  output logic [ADDR_W-1:0] mem_addr_1,
  output logic [DATA_W-1:0] mem_din_1,
  output logic              mem_we_1,
  output logic              mem_re_1,
  input  logic [DATA_W-1:0] mem_dout
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] init_cnt;
  logic [CW-1:0] wr_ch, rd_ch;
  logic [SW-1:0] wr_slot, rd_slot;
  logic run, full, sof_in, wr_acc, commit, fetch, rel;
  assign run = state == RUN;
  assign full = frames_avail == FW'(NUM_FRAMES);
  assign sof_in = run && bus.wr_valid && bus.wr_sof;
  // a frame is open exactly when wr_ch is past channel 0, so no separate open flag is kept
  assign wr_acc = sof_in ? !full : (run && bus.wr_valid && wr_ch != '0);
  assign commit = wr_acc && !bus.wr_sof && wr_ch == CW'(CH - 1);
  // a frame whose last word sits in the output register is fully fetched but not yet released
  assign fetch = run && frames_avail > FW'(bus.rd_valid && bus.rd_last) && (!bus.rd_valid || bus.rd_ready);
  assign rel = bus.rd_valid && bus.rd_ready && bus.rd_last;
  assign bus.wr_ready = run;
  assign mem_re_0 = 1'b0;
  assign mem_we_1 = 1'b0;
  assign mem_din_1 = '0;
  assign mem_re_1 = fetch;
  assign mem_addr_1 = (ADDR_W'(rd_slot) << CW) | ADDR_W'(rd_ch);
  // next state and port-0 drive: zero-fill in INIT, ADC samples in RUN
  always_comb begin
    state_nx = clear ? INIT : (!run && &init_cnt) ? RUN : state;
    mem_we_0 = !run || wr_acc;
    mem_addr_0 = run ? ((ADDR_W'(wr_slot) << CW) | ADDR_W'(sof_in ? CW'(0) : wr_ch)) : init_cnt;
    mem_din_0 = run ? bus.wr_data : '0;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_nx;
  // zero-fill address counter, held at 0 outside INIT and restarted by clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) init_cnt <= '0;
    else init_cnt <= (clear || run) ? '0 : init_cnt + ADDR_W'(1);
  // write pointer: sof restarts the current slot, the last channel commits and moves on
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ch <= '0;
      wr_slot <= '0;
    end else if (clear) begin
      wr_ch <= '0;
      wr_slot <= '0;
    end else if (wr_acc) begin
      wr_ch <= bus.wr_sof ? CW'(1) : wr_ch + CW'(1);
      if (commit) wr_slot <= (wr_slot == SW'(NUM_FRAMES - 1)) ? '0 : wr_slot + SW'(1);
    end
  // committed-frame count: commit and release in one cycle cancel out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frames_avail <= '0;
    else if (clear) frames_avail <= '0;
    else if (commit != rel) frames_avail <= commit ? frames_avail + FW'(1) : frames_avail - FW'(1);
  // error status: saturating drop counter and sticky mid-frame sof flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_cnt <= '0;
      sof_err <= 1'b0;
    end else if (clear) begin
      ovf_cnt <= '0;
      sof_err <= 1'b0;
    end else begin
      if (sof_in && full && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + 8'd1;
      if (sof_in && wr_ch != '0) sof_err <= 1'b1;
    end
  // read side: fetch pointer plus output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ch <= '0;
      rd_slot <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_last <= 1'b0;
    end else if (clear) begin
      rd_ch <= '0;
      rd_slot <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_last <= 1'b0;
    end else begin
      bus.rd_valid <= fetch || (bus.rd_valid && !bus.rd_ready);
      if (fetch) begin
        rd_ch <= rd_ch + CW'(1);
        if (&rd_ch) rd_slot <= (rd_slot == SW'(NUM_FRAMES - 1)) ? '0 : rd_slot + SW'(1);
        bus.rd_data <= mem_dout;
        bus.rd_last <= &rd_ch;
      end
    end
endmodule

// File: tb/tb_adcmem_frame_ctrl.sv
// tb_adcmem_frame_ctrl: scoreboard bench for the frame ring controller with a behavioural memory
module tb_adcmem_frame_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic [3:0] frames_avail;
  logic [7:0] ovf_cnt;
  logic sof_err;
  logic [8:0] mem_addr_0, mem_addr_1;
  logic [15:0] mem_din_0, mem_din_1, mem_dout;
  logic mem_we_0, mem_re_0, mem_we_1, mem_re_1;
  logic [15:0] mem [512];
  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q [$];
  logic [8:0] wlog [$];
  bit bp = 0;
  bit rd_en = 0;
  bit log_en = 0;
  bit prev_stall = 0;
  logic [16:0] prev_word;
  adcmem_frame_ctrl_if bus();
  adcmem_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
    .frames_avail(frames_avail), .ovf_cnt(ovf_cnt), .sof_err(sof_err),
    .mem_addr_0(mem_addr_0), .mem_din_0(mem_din_0), .mem_we_0(mem_we_0), .mem_re_0(mem_re_0),
    .mem_addr_1(mem_addr_1), .mem_din_1(mem_din_1), .mem_we_1(mem_we_1), .mem_re_1(mem_re_1),
    .mem_dout(mem_dout)
  );
  initial forever #5 clk = ~clk;
  always @(posedge clk) if (mem_we_0) mem[mem_addr_0] <= mem_din_0;
  assign mem_dout = mem[mem_addr_1];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask
  initial begin
    bus.rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rd_ready = bp ? 1'($urandom_range(0, 1)) : rd_en;
    end
  end
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      chk("hold_valid", bus.rd_valid, 1);
      chk("hold_word", {bus.rd_last, bus.rd_data}, prev_word);
    end
    if (rst_n && bus.rd_valid && bus.rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_word: got unexpected %0h, required no word", {bus.rd_last, bus.rd_data});
      end else chk("rd_word", {bus.rd_last, bus.rd_data}, exp_q.pop_front());
    end
    prev_stall = rst_n && bus.rd_valid && !bus.rd_ready;
    prev_word = {bus.rd_last, bus.rd_data};
    if (log_en && mem_we_0) wlog.push_back(mem_addr_0);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  task automatic send(input int base, input int n, input bit push);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b1;
      bus.wr_sof = i == 0;
      bus.wr_data = 16'(base + i);
      if (push) exp_q.push_back({i == 63, 16'(base + i)});
    end
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    bus.wr_sof = 1'b0;
  endtask
  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d words left, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic check_fill(input string name);
    int bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (!(mem_we_0 === 1'b1 && mem_addr_0 === 9'(i) && mem_din_0 === 16'h0 && bus.wr_ready === 1'b0 && bus.rd_valid === 1'b0)) bad++;
      @(negedge clk);
    end
    chk({name, "_bad_cycles"}, bad, 0);
    chk({name, "_wr_ready"}, bus.wr_ready, 1);
    chk({name, "_frames_avail"}, frames_avail, 0);
  endtask
  initial begin
    int bad;
    int n;
    bus.wr_valid = 1'b0;
    bus.wr_sof = 1'b0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_frames_avail", frames_avail, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("tie_offs", {mem_re_0, mem_we_1, mem_din_1}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_fill("fill_reset");
    rd_en = 1;
    send(0, 64, 1);
    @(negedge clk);
    chk("one_avail", frames_avail, 1);
    chk("one_fetch_lat", {bus.rd_valid, mem_re_1, mem_addr_1}, {2'b01, 9'd0});
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (!(bus.rd_valid && bus.rd_data == 16'(i) && bus.rd_last == (i == 63))) bad++;
      @(negedge clk);
    end
    chk("one_consecutive_bad", bad, 0);
    drain(100);
    chk("one_avail_after", frames_avail, 0);
    rd_en = 0;
    send(300, 64, 1);
    repeat (3) @(negedge clk);
    chk("areset_pre_avail", frames_avail, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_rd_valid", bus.rd_valid, 0);
    chk("areset_avail", frames_avail, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_fill("fill_areset");
    for (int f = 0; f < 9; f++) begin
      if (f == 8) log_en = 1;
      send(1000 * (f + 1), 64, f < 8);
    end
    @(negedge clk);
    log_en = 0;
    chk("ovf_drop_writes", wlog.size(), 0);
    chk("ovf_avail", frames_avail, 8);
    chk("ovf_cnt", ovf_cnt, 1);
    rd_en = 1;
    n = 0;
    while (exp_q.size() > 7 * 64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_first_read", exp_q.size() <= 7 * 64, 1);
    rd_en = 0;
    repeat (4) @(negedge clk);
    log_en = 1;
    send(10000, 64, 1);
    @(negedge clk);
    log_en = 0;
    chk("ovf_10th_writes", wlog.size(), 64);
    bad = 0;
    foreach (wlog[i]) if (wlog[i] != 9'(i)) bad++;
    chk("ovf_10th_slot0_bad", bad, 0);
    rd_en = 1;
    drain(1000);
    chk("ovf_avail_after", frames_avail, 0);
    rd_en = 0;
    bp = 1;
    for (int f = 0; f < 3; f++) send(40000 + 100 * f, 64, 1);
    drain(2000);
    bp = 0;
    chk("bp_avail_after", frames_avail, 0);
    send(500, 10, 0);
    send(600, 64, 1);
    @(negedge clk);
    chk("short_sof_err", sof_err, 1);
    chk("short_avail", frames_avail, 1);
    chk("pre_clear_ovf", ovf_cnt, 1);
    rd_en = 1;
    n = 0;
    while (exp_q.size() > 44 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("clear_reach_word20", exp_q.size(), 44);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("clear_rd_valid", bus.rd_valid, 0);
    check_fill("fill_clear");
    chk("clear_ovf_cnt", ovf_cnt, 0);
    chk("clear_sof_err", sof_err, 0);
    send(20000, 64, 1);
    drain(200);
    chk("post_clear_avail", frames_avail, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
